// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write hazard tracker for the 8x16 pipeline register file.
// Define SCOREBOARD_STATS_EN to add the saturating stall_cycles counter output.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic                            issue_writes,
    input  logic [ADDR_WIDTH-1:0]           issue_dest,
    input  logic                            src1_used,
    input  logic [ADDR_WIDTH-1:0]           src1_addr,
    input  logic                            src2_used,
    input  logic [ADDR_WIDTH-1:0]           src2_addr,
    input  logic                            wb_valid,
    input  logic [ADDR_WIDTH-1:0]           wb_addr,
    input  logic                            flush,
    output logic                            stall,
    output logic [2**ADDR_WIDTH-1:0]        busy_mask,
    output logic [ADDR_WIDTH+CNT_WIDTH-1:0] outstanding,
    output logic                            wb_underflow
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0]                     stall_cycles
`endif
);
    localparam int NREGS = 2**ADDR_WIDTH;
    localparam int OW = ADDR_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX_PEND = '1;
    logic [CNT_WIDTH-1:0] pend     [NREGS];
    logic [CNT_WIDTH-1:0] pend_nxt [NREGS];
    logic [CNT_WIDTH-1:0] eff      [NREGS];
    logic [NREGS-1:0] inc, dec, busy_nxt;
    logic [OW-1:0] sum_nxt;
    logic accept;
    // A same-cycle writeback lands before the negedge read, so it already clears the hazard.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            dec[r] = wb_valid && wb_addr == ADDR_WIDTH'(r) && pend[r] != '0;
            eff[r] = pend[r] - CNT_WIDTH'(dec[r]);
        end
    end
    assign stall = !rst && issue_valid && !flush &&
                   ((src1_used && eff[src1_addr] != '0) ||
                    (src2_used && eff[src2_addr] != '0) ||
                    (issue_writes && eff[issue_dest] == MAX_PEND));
    assign accept = issue_valid && !stall && !flush;
    always_comb begin
        sum_nxt = '0;
        for (int r = 0; r < NREGS; r++) begin
            inc[r] = accept && issue_writes && issue_dest == ADDR_WIDTH'(r);
            pend_nxt[r] = flush ? '0 : pend[r] + CNT_WIDTH'(inc[r]) - CNT_WIDTH'(dec[r]);
            busy_nxt[r] = pend_nxt[r] != '0;
            sum_nxt = sum_nxt + OW'(pend_nxt[r]);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend         <= '{default: '0};
            busy_mask    <= '0;
            outstanding  <= '0;
            wb_underflow <= 1'b0;
        end else begin
            pend        <= pend_nxt;
            busy_mask   <= busy_nxt;
            outstanding <= sum_nxt;
            if (!flush && wb_valid && pend[wb_addr] == '0)
                wb_underflow <= 1'b1;
        end
    end
`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: vector table with a queue of expected registered results, plus async-reset sequence.
module tb_regfile_scoreboard;
    logic clk, rst;
    logic issue_valid, issue_writes, src1_used, src2_used, wb_valid, flush;
    logic [2:0] issue_dest, src1_addr, src2_addr, wb_addr;
    logic stall, wb_underflow;
    logic [7:0] busy_mask;
    logic [4:0] outstanding;
`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles;
`endif

    regfile_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
        .src1_used(src1_used), .src1_addr(src1_addr),
        .src2_used(src2_used), .src2_addr(src2_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .stall(stall), .busy_mask(busy_mask), .outstanding(outstanding),
        .wb_underflow(wb_underflow)
`ifdef SCOREBOARD_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic iv, iw; logic [2:0] dest;
        logic s1u; logic [2:0] s1;
        logic s2u; logic [2:0] s2;
        logic wv; logic [2:0] wa; logic fl;
        logic st; logic [7:0] busy; logic [4:0] outs; logic uf;
    } vec_t;
    typedef struct { int idx; logic [7:0] busy; logic [4:0] outs; logic uf; } exp_t;

    vec_t vec [23];
    exp_t q [$];
    int n_checks = 0, n_fail = 0, n_stalls = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion before 100000");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_writes = v.iw; issue_dest = v.dest;
        src1_used = v.s1u; src1_addr = v.s1;
        src2_used = v.s2u; src2_addr = v.s2;
        wb_valid = v.wv; wb_addr = v.wa; flush = v.fl;
    endtask

    task automatic pop_check();
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check($sformatf("v%0d busy_mask", e.idx), 32'(busy_mask), 32'(e.busy));
            check($sformatf("v%0d outstanding", e.idx), 32'(outstanding), 32'(e.outs));
            check($sformatf("v%0d wb_underflow", e.idx), 32'(wb_underflow), 32'(e.uf));
        end
    endtask

    initial begin
        //         iv iw d  s1u s1 s2u s2 wv wa fl   st busy  out uf
        vec[0]  = '{1, 1, 3, 0, 0, 0, 0, 0, 0, 0,   0, 8'h08, 1, 0};
        vec[1]  = '{1, 0, 0, 1, 3, 0, 0, 0, 0, 0,   1, 8'h08, 1, 0};
        vec[2]  = '{1, 0, 0, 1, 3, 0, 0, 1, 3, 0,   0, 8'h00, 0, 0};
        vec[3]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 8'h20, 1, 0};
        vec[4]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 8'h20, 2, 0};
        vec[5]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 8'h20, 3, 0};
        vec[6]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   1, 8'h20, 3, 0};
        vec[7]  = '{1, 1, 5, 0, 0, 0, 0, 1, 5, 0,   0, 8'h20, 3, 0};
        vec[8]  = '{1, 0, 0, 0, 0, 1, 5, 0, 0, 0,   1, 8'h20, 3, 0};
        vec[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 5, 0,   0, 8'h20, 2, 0};
        vec[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 5, 0,   0, 8'h20, 1, 0};
        vec[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 5, 0,   0, 8'h00, 0, 0};
        vec[12] = '{1, 1, 2, 0, 0, 0, 0, 0, 0, 0,   0, 8'h04, 1, 0};
        vec[13] = '{1, 1, 2, 0, 0, 0, 0, 1, 2, 0,   0, 8'h04, 1, 0};
        vec[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   0, 8'h04, 1, 1};
        vec[15] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 8'h06, 2, 1};
        vec[16] = '{1, 1, 4, 0, 0, 0, 0, 0, 0, 0,   0, 8'h16, 3, 1};
        vec[17] = '{1, 1, 6, 0, 0, 0, 0, 0, 0, 0,   0, 8'h56, 4, 1};
        vec[18] = '{1, 1, 1, 1, 1, 0, 0, 1, 4, 1,   0, 8'h00, 0, 1};
        vec[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8'h00, 0, 1};
        vec[20] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 8'h01, 1, 1};
        vec[21] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8'h01, 1, 1};
        vec[22] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 8'h00, 0, 1};

        rst = 1'b0;
        drive(vec[19]);
        #2 rst = 1'b1;
        issue_valid = 1'b1; src1_used = 1'b1; src1_addr = 3'd3;
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset busy_mask", 32'(busy_mask), 32'd0);
        check("reset outstanding", 32'(outstanding), 32'd0);
        check("reset wb_underflow", 32'(wb_underflow), 32'd0);
`ifdef SCOREBOARD_STATS_EN
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);
`endif
        drive(vec[19]);
        @(posedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1;
            pop_check();
            drive(vec[i]);
            #1;
            check($sformatf("v%0d stall", i), 32'(stall), 32'(vec[i].st));
            if (vec[i].st) n_stalls++;
            q.push_back('{i, vec[i].busy, vec[i].outs, vec[i].uf});
        end
        @(posedge clk);
        #1;
        pop_check();
        drive(vec[19]);
        check("queue drained", 32'(q.size()), 32'd0);
`ifdef SCOREBOARD_STATS_EN
        check("stall_cycles after table", 32'(stall_cycles), 32'(n_stalls));
`endif

        // Producer on R6, dependent reader held for two edges, then async reset between edges.
        issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = 3'd6;
        @(posedge clk);
        #1;
        check("seq busy R6", 32'(busy_mask), 32'h40);
        issue_writes = 1'b0; src1_used = 1'b1; src1_addr = 3'd6;
        #1;
        check("seq stall on R6", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        check("seq stall held", 32'(stall), 32'd1);
        @(posedge clk);
        #2;
`ifdef SCOREBOARD_STATS_EN
        check("seq stall_cycles", 32'(stall_cycles), 32'(n_stalls + 2));
`endif
        rst = 1'b1;
        #1;
        check("async rst stall", 32'(stall), 32'd0);
        check("async rst busy_mask", 32'(busy_mask), 32'd0);
        check("async rst outstanding", 32'(outstanding), 32'd0);
        check("async rst wb_underflow", 32'(wb_underflow), 32'd0);
`ifdef SCOREBOARD_STATS_EN
        check("async rst stall_cycles", 32'(stall_cycles), 32'd0);
`endif
        #1 rst = 1'b0;
        drive(vec[19]);
        @(posedge clk);
        #1;
        check("post rst busy_mask", 32'(busy_mask), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
